// File: rtl/arb_pkg.sv
// Shared arbiter definitions: priority mode constants and a rotating one-hot pick.
package arb_pkg;

    localparam int ARB_STATIC = 0;
    localparam int ARB_RR     = 1;
    localparam int ARB_MAXN   = 16;
    localparam int ARB_PW     = 4;
    localparam int ARB_JW     = ARB_PW + 1;

    // First set bit of v at or after ptr, wrapping modulo n; zero if none.
    function automatic logic [ARB_MAXN-1:0] arb_rotate_pick(
        input logic [ARB_MAXN-1:0] v,
        input logic [ARB_PW-1:0]   ptr,
        input logic [ARB_JW-1:0]   n
    );
        logic [ARB_MAXN-1:0] r;
        logic                found;
        logic [ARB_JW-1:0]   j;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_MAXN; i++) begin
            j = {1'b0, ptr} + ARB_JW'(i);
            if (j >= n) begin
                j = j - n;
            end
            if (i < int'(n) && !found && v[j[ARB_PW-1:0]]) begin
                r[j[ARB_PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational pointer-rotated pick: one-hot winner plus its encoded index.
module arb_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   v,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id
);

    assign win = N'(arb_rotate_pick(ARB_MAXN'(v), ARB_PW'(ptr), ARB_JW'(N)));

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/arb_param.sv
// N-channel hold-until-release arbiter, static or round-robin priority.
// Define ARB_TIMEOUT_EN to force release of owners held for MAX_HOLD cycles.
module arb_param
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int RR       = ARB_RR,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   ack,
    output logic [IDW-1:0] ack_id,
    output logic           busy,
    output logic           tmo
);

    if (N < 2 || N > ARB_MAXN) begin : g_bad_n
        $error("arb_param: N must be 2..16");
    end
    if (RR != ARB_STATIC && RR != ARB_RR) begin : g_bad_rr
        $error("arb_param: RR must be 0 or 1");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("arb_param: MAX_HOLD must be positive");
    end

    logic [N-1:0]   r_ack;
    logic [IDW-1:0] r_id;
    logic           r_busy;
    logic           r_tmo;
    logic [IDW-1:0] r_ptr;

    logic [N-1:0]   w_pick_v;
    logic [N-1:0]   w_win;
    logic [IDW-1:0] w_win_id;
    logic [IDW-1:0] w_next;
    logic           w_hold;
    logic           w_expire;

    // Masking the owner only matters on timeout; on release req[owner] is already low.
    assign w_pick_v = req & ~r_ack;
    assign w_hold   = |(r_ack & req);
    assign w_next   = (w_win_id == IDW'(N - 1)) ? '0 : w_win_id + 1'b1;

    arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .v      (w_pick_v),
        .ptr    (r_ptr),
        .win    (w_win),
        .win_id (w_win_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] r_cnt;

    // r_cnt counts hold edges; the grant edge itself is cycle one.
    assign w_expire = w_hold && (r_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_hold || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= '0;
            r_id   <= '0;
            r_busy <= 1'b0;
            r_tmo  <= 1'b0;
            r_ptr  <= '0;
        end else begin
            r_tmo <= w_expire;
            if (!w_hold || w_expire) begin
                r_ack  <= w_win;
                r_id   <= w_win_id;
                r_busy <= |w_win;
                if (RR == ARB_RR && |w_win) begin
                    r_ptr <= w_next;
                end
            end
        end
    end

    assign ack    = r_ack;
    assign ack_id = r_id;
    assign busy   = r_busy;
    assign tmo    = r_tmo;

endmodule

// File: tb/tb_arb_param.sv
// Directed bench for arb_param: round-robin N=4 and static N=3 instances.
// Timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_arb_param;

    logic       clk;
    logic       rst;
    logic [3:0] req_rr;
    logic [3:0] ack_rr;
    logic [1:0] id_rr;
    logic       busy_rr;
    logic       tmo_rr;
    logic [2:0] req_st;
    logic [2:0] ack_st;
    logic [1:0] id_st;
    logic       busy_st;
    logic       tmo_st;

    int n_checks;
    int n_fail;

    arb_param #(
        .N        (4),
        .RR       (1),
        .MAX_HOLD (4)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_rr),
        .ack    (ack_rr),
        .ack_id (id_rr),
        .busy   (busy_rr),
        .tmo    (tmo_rr)
    );

    arb_param #(
        .N  (3),
        .RR (0)
    ) u_st (
        .clk    (clk),
        .rst    (rst),
        .req    (req_st),
        .ack    (ack_st),
        .ack_id (id_st),
        .busy   (busy_st),
        .tmo    (tmo_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_rr = '0;
        req_st = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_rr = 4'b1111;
        req_st = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (ack_rr !== 4'b0000 || id_rr !== 2'd0 || busy_rr !== 1'b0 || tmo_rr !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d ack=%b id=%0d busy=%b tmo=%b want 0000/0/0/0",
                         c, ack_rr, id_rr, busy_rr, tmo_rr);
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (ack_rr !== 4'b0001 || id_rr !== 2'd0 || busy_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first ack=%b id=%0d busy=%b want 0001/0/1", ack_rr, id_rr, busy_rr);
        end
        req_rr = '0;
        step();
        n_checks++;
        if (ack_rr !== 4'b0000 || busy_rr !== 1'b0 || id_rr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle ack=%b id=%0d busy=%b want 0000/0/0", ack_rr, id_rr, busy_rr);
        end
    endtask

    task automatic test_static();
        logic [2:0] vin [5];
        logic [2:0] vexp[5];
        vin[0] = 3'b110; vexp[0] = 3'b010;
        vin[1] = 3'b111; vexp[1] = 3'b010;
        vin[2] = 3'b111; vexp[2] = 3'b010;
        vin[3] = 3'b101; vexp[3] = 3'b001;
        vin[4] = 3'b000; vexp[4] = 3'b000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_st = vin[i];
            step();
            n_checks++;
            if (ack_st !== vexp[i] || busy_st !== (vexp[i] != 3'b000) || tmo_st !== 1'b0) begin
                n_fail++;
                $display("FAIL static i=%0d ack=%b busy=%b want %b", i, ack_st, busy_st, vexp[i]);
            end
        end
        n_checks++;
        if (id_st !== 2'd0) begin
            n_fail++;
            $display("FAIL static_idle_id id=%0d want 0", id_st);
        end
    endtask

    task automatic test_round_robin();
        int nxt;
        do_reset();
        req_rr = 4'b1111;
        step();
        n_checks++;
        if (ack_rr !== 4'b0001 || id_rr !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_first ack=%b id=%0d want 0001/0", ack_rr, id_rr);
        end
        for (int k = 0; k < 4; k++) begin
            nxt = (k + 1) % 4;
            req_rr = 4'b1111;
            step();
            n_checks++;
            if (ack_rr !== 4'(1 << k) || id_rr !== 2'(k)) begin
                n_fail++;
                $display("FAIL rr_hold k=%0d ack=%b id=%0d want ch%0d", k, ack_rr, id_rr, k);
            end
            req_rr = 4'b1111 & ~4'(1 << k);
            step();
            n_checks++;
            if (ack_rr !== 4'(1 << nxt) || id_rr !== 2'(nxt) || $countones(ack_rr) > 1) begin
                n_fail++;
                $display("FAIL rr_order k=%0d ack=%b id=%0d want ch%0d", k, ack_rr, id_rr, nxt);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_rr = 4'b0100;
        step();
        req_rr = 4'b0000;
        step();
        n_checks++;
        if (ack_rr !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_idle ack=%b want 0000", ack_rr);
        end
        req_rr = 4'b0101;
        step();
        n_checks++;
        if (ack_rr !== 4'b0001 || id_rr !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_wrap ack=%b id=%0d want 0001/0", ack_rr, id_rr);
        end
        req_rr = 4'b0100;
        step();
        n_checks++;
        if (ack_rr !== 4'b0100 || id_rr !== 2'd2 || busy_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_handover ack=%b id=%0d busy=%b want 0100/2/1", ack_rr, id_rr, busy_rr);
        end
    endtask

    task automatic test_reset_mid_grant();
        // Continues from the ch2 grant left by test_back_to_back.
        step();
        n_checks++;
        if (ack_rr !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_hold ack=%b want 0100", ack_rr);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (ack_rr !== 4'b0000 || busy_rr !== 1'b0 || id_rr !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_rst ack=%b id=%0d busy=%b want 0000/0/0", ack_rr, id_rr, busy_rr);
        end
        rst    = 1'b0;
        req_rr = 4'b0110;
        step();
        n_checks++;
        if (ack_rr !== 4'b0010 || id_rr !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_after ack=%b id=%0d want 0010/1", ack_rr, id_rr);
        end
        // Pointer now sits at 2; a reset must bring it back to 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (ack_rr !== 4'b0010 || id_rr !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_ptr_clear ack=%b id=%0d want 0010/1", ack_rr, id_rr);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_rr = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (ack_rr !== 4'b0001 || tmo_rr !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_hold c=%0d ack=%b tmo=%b want 0001/0", c, ack_rr, tmo_rr);
            end
        end
        step();
        n_checks++;
        if (ack_rr !== 4'b0010 || tmo_rr !== 1'b1 || id_rr !== 2'd1) begin
            n_fail++;
            $display("FAIL tmo_switch ack=%b id=%0d tmo=%b want 0010/1/1", ack_rr, id_rr, tmo_rr);
        end
        step();
        n_checks++;
        if (ack_rr !== 4'b0010 || tmo_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse ack=%b tmo=%b want 0010/0", ack_rr, tmo_rr);
        end
        do_reset();
        req_rr = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step();
        end
        n_checks++;
        if (ack_rr !== 4'b0100 || tmo_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_single_hold ack=%b tmo=%b want 0100/0", ack_rr, tmo_rr);
        end
        step();
        n_checks++;
        if (ack_rr !== 4'b0000 || tmo_rr !== 1'b1 || busy_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_single_drop ack=%b tmo=%b busy=%b want 0000/1/0", ack_rr, tmo_rr, busy_rr);
        end
        step();
        n_checks++;
        if (ack_rr !== 4'b0100 || tmo_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_regrant ack=%b tmo=%b want 0100/0", ack_rr, tmo_rr);
        end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        req_rr = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (ack_rr !== 4'b0001 || tmo_rr !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever c=%0d ack=%b tmo=%b want 0001/0", c, ack_rr, tmo_rr);
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req_rr   = '0;
        req_st   = '0;
        test_reset();
        test_static();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
